// File: rtl/serial_tx.sv
// Serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// txd is registered; d_ready/busy decode the current state only.
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] d,
   input  logic              d_valid,
   output logic              d_ready,
   output logic              txd,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic [15:0]       CNT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [DATA_W-1:0] IDX_LAST = DATA_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] IDX_ONE  = DATA_W'(1);

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              par_q, par_d;
   logic              txd_q, txd_d;
   logic              bit_done;

   assign bit_done = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      par_d   = par_q;
      txd_d   = txd_q;

      if (state_q != IDLE) begin
         cnt_d = bit_done ? '0 : cnt_q + 16'd1;
      end

      // txd_d always carries the value of the bit about to start
      unique case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (d_valid) begin
               sh_d    = d;
               par_d   = ^d;
               idx_d   = '0;
               cnt_d   = '0;
               txd_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_done) begin
               txd_d   = sh_q[0];
               sh_d    = sh_q >> 1;
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (idx_q == IDX_LAST) begin
                  if (PARITY_EN != 0) begin
                     txd_d   = par_q;
                     state_d = PARITY;
                  end else begin
                     txd_d   = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  idx_d = idx_q + IDX_ONE;
                  txd_d = sh_q[0];
                  sh_d  = sh_q >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               txd_d   = 1'b1;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               txd_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            txd_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
      end
   end

   assign d_ready = (state_q == IDLE);
   assign busy    = (state_q != IDLE);
   assign txd     = txd_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default build plus a 1-clk/bit no-parity build.
module tb_serial_tx;

   logic       clk;
   logic       reset;
   logic [7:0] d;
   logic       d_valid;
   logic       d_ready;
   logic       txd;
   logic       busy;
   logic [7:0] d_b;
   logic       dv_b;
   logic       rdy_b;
   logic       txd_b;
   logic       busy_b;

   int total = 0;
   int bad   = 0;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_a (
      .clk     (clk),
      .reset   (reset),
      .d       (d),
      .d_valid (d_valid),
      .d_ready (d_ready),
      .txd     (txd),
      .busy    (busy)
   );

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_b (
      .clk     (clk),
      .reset   (reset),
      .d       (d_b),
      .d_valid (dv_b),
      .d_ready (rdy_b),
      .txd     (txd_b),
      .busy    (busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      check({tag, " txd"}, 32'(txd), 32'd1);
      check({tag, " rdy"}, 32'(d_ready), 32'd1);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   // bits[i] is the i-th serial bit; called in the first START cycle
   task automatic run_frame(input string tag, input logic [10:0] bits,
                            input int poke);
      int k;
      logic b;
      k = 0;
      for (int i = 0; i < 11; i++) begin
         b = bits[i];
         for (int c = 0; c < 4; c++) begin
            if (poke >= 0 && k == poke) begin
               d       = 8'hFF;
               d_valid = 1'b1;
            end else if (poke >= 0 && k == poke + 1) begin
               d_valid = 1'b0;
            end
            check($sformatf("%s txd b%0d", tag, i), 32'(txd), 32'(b));
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " rdy"}, 32'(d_ready), 32'd0);
            tick();
            k++;
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      d       = 8'h55;
      d_valid = 1'b1;
      d_b     = 8'h00;
      dv_b    = 1'b0;

      // long reset with a word offered throughout
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("rst hold");
      end
      reset   = 1'b0;
      d_valid = 1'b0;
      tick();
      chk_idle("post rst");

      // 0xA5: 0,10100101 LSB first, parity 0, stop
      d       = 8'hA5;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      run_frame("a5", 11'b101_0100_1010, -1);
      chk_idle("a5 end");

      // 0x01 with d_valid held: parity 1, back-to-back after one idle
      d       = 8'h01;
      d_valid = 1'b1;
      tick();
      run_frame("01a", 11'b110_0000_0010, -1);
      chk_idle("01 gap");
      tick();
      d_valid = 1'b0;
      run_frame("01b", 11'b110_0000_0010, -1);
      chk_idle("01 end");

      // 0x00 with a 0xFF pulse mid-frame
      d       = 8'h00;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      run_frame("00", 11'b100_0000_0000, 13);
      for (int i = 0; i < 6; i++) begin
         chk_idle("no ff");
         tick();
      end

      // reset in cycle 20 of a 0x3C frame
      d       = 8'h3C;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      check("3c start", 32'(txd), 32'd0);
      for (int i = 1; i < 20; i++) tick();
      check("3c busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         chk_idle("3c abort");
         tick();
      end

      // reset and accept on the same edge
      reset   = 1'b1;
      d       = 8'h00;
      d_valid = 1'b1;
      tick();
      reset   = 1'b0;
      d_valid = 1'b0;
      chk_idle("rst+acc");
      tick();
      chk_idle("rst+acc2");

      // 1 clk per bit, no parity: 0x80
      d_b  = 8'h80;
      dv_b = 1'b1;
      tick();
      dv_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("b80 txd %0d", i), 32'(txd_b), (i >= 8) ? 32'd1 : 32'd0);
         check("b80 busy", 32'(busy_b), 32'd1);
         tick();
      end
      check("b80 idle rdy", 32'(rdy_b), 32'd1);
      check("b80 idle busy", 32'(busy_b), 32'd0);
      check("b80 idle txd", 32'(txd_b), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
